// File: rtl/skew_feeder.sv
// skew_feeder: fetches one pair of GRID_SIZE x GRID_SIZE byte operands (A, B)
// from a byte memory. It then streams them diagonally skewed into the west and
// north lanes of a systolic array, followed by zero-valued drain cycles.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 one-cycle request, a_base/b_base sampled with it
//   a_base, b_base        row-major byte addresses of A and B
//   mem_rd, mem_addr      memory read strobe/address (data one cycle later)
//   mem_rdata             read data byte
//   busy, done            operation in flight / one-cycle completion pulse
//   ce                    systolic-array clock enable
//   west_input            row lanes, lane i at [(i+1)*NUM_SIZE-1 : i*NUM_SIZE]
//   north_input           column lanes, same packing
//
// Configuration: define SKEW_FEEDER_SIGNED_EN to sign-extend fetched bytes;
// they are zero-extended otherwise.
module skew_feeder #(
   parameter int unsigned NUM_SIZE     = 16,
   parameter int unsigned GRID_SIZE    = 2,
   parameter int unsigned ADDR_LEN     = 5,
   parameter int unsigned DRAIN_CYCLES = 3
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            start,
   input  logic [ADDR_LEN-1:0]             a_base,
   input  logic [ADDR_LEN-1:0]             b_base,
   output logic                            mem_rd,
   output logic [ADDR_LEN-1:0]             mem_addr,
   input  logic [7:0]                      mem_rdata,
   output logic                            busy,
   output logic                            done,
   output logic                            ce,
   output logic [NUM_SIZE*GRID_SIZE-1:0]   west_input,
   output logic [NUM_SIZE*GRID_SIZE-1:0]   north_input
);

   localparam int unsigned NUM_ELEM  = GRID_SIZE * GRID_SIZE;
   localparam int unsigned NUM_READS = 2 * NUM_ELEM;
   localparam int unsigned NUM_STEPS = 2 * GRID_SIZE - 1;
   localparam int unsigned CNT_MAX   = (NUM_READS > DRAIN_CYCLES) ? NUM_READS : DRAIN_CYCLES;
   localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
   localparam int unsigned LANES_W   = NUM_SIZE * GRID_SIZE;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      STREAM = 3'd2,
      DRAIN  = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [ADDR_LEN-1:0]    a_base_q, a_base_d;
   logic [ADDR_LEN-1:0]    b_base_q, b_base_d;
   logic                   rd_vld_q, rd_vld_d;
   logic [CNT_W-1:0]       rd_idx_q, rd_idx_d;
   // ops[0 .. NUM_ELEM-1] = A row-major, ops[NUM_ELEM ..] = B row-major
   logic [NUM_SIZE-1:0]    ops_q [NUM_READS];
   logic [NUM_SIZE-1:0]    ops_d [NUM_READS];
   logic                   mem_rd_q, mem_rd_d;
   logic [ADDR_LEN-1:0]    mem_addr_q, mem_addr_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   ce_q, ce_d;
   logic [LANES_W-1:0]     west_q, west_d;
   logic [LANES_W-1:0]     north_q, north_d;

   // Byte to lane-width extension
   function automatic logic [NUM_SIZE-1:0] ext_byte(input logic [7:0] b);
`ifdef SKEW_FEEDER_SIGNED_EN
      return NUM_SIZE'($signed(b));
`else
      return NUM_SIZE'(b);
`endif
   endfunction

   // Next-state, operand capture and next-output logic
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_base_d = a_base_q;
      b_base_d = b_base_q;
      ops_d    = ops_q;
      // the read issued this cycle returns next cycle; remember its slot
      rd_vld_d = mem_rd_q;
      rd_idx_d = cnt_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               a_base_d = a_base;
               b_base_d = b_base;
               state_d  = FETCH;
               cnt_d    = '0;
            end
         end
         FETCH: begin
            // one extra cycle after the last read to collect its data
            if (cnt_q == CNT_W'(NUM_READS)) begin
               state_d = STREAM;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         STREAM: begin
            if (cnt_q == CNT_W'(NUM_STEPS - 1)) begin
               state_d = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DRAIN: begin
            if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
               state_d = DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      if (rd_vld_q) begin
         for (int unsigned k = 0; k < NUM_READS; k++) begin
            if (rd_idx_q == CNT_W'(k)) ops_d[k] = ext_byte(mem_rdata);
         end
      end

      // outputs are computed for the upcoming cycle and registered
      mem_rd_d   = (state_d == FETCH) && (cnt_d < CNT_W'(NUM_READS));
      mem_addr_d = '0;
      if (mem_rd_d) begin
         if (cnt_d < CNT_W'(NUM_ELEM)) begin
            mem_addr_d = a_base_d + ADDR_LEN'(cnt_d);
         end else begin
            mem_addr_d = b_base_d + ADDR_LEN'(cnt_d - CNT_W'(NUM_ELEM));
         end
      end
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
      ce_d   = (state_d == STREAM) || (state_d == DRAIN);

      // Diagonal skew: at step t, lane i carries element k of its row/column
      // where t = i + k.
      west_d  = '0;
      north_d = '0;
      if (state_d == STREAM) begin
         for (int unsigned i = 0; i < GRID_SIZE; i++) begin
            for (int unsigned k = 0; k < GRID_SIZE; k++) begin
               if (cnt_d == CNT_W'(i + k)) begin
                  west_d[i*NUM_SIZE +: NUM_SIZE]  = ops_d[i*GRID_SIZE + k];
                  north_d[i*NUM_SIZE +: NUM_SIZE] = ops_d[NUM_ELEM + k*GRID_SIZE + i];
               end
            end
         end
      end
   end

   // State, operand and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         a_base_q   <= '0;
         b_base_q   <= '0;
         rd_vld_q   <= 1'b0;
         rd_idx_q   <= '0;
         for (int unsigned k = 0; k < NUM_READS; k++) ops_q[k] <= '0;
         mem_rd_q   <= 1'b0;
         mem_addr_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         ce_q       <= 1'b0;
         west_q     <= '0;
         north_q    <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         a_base_q   <= a_base_d;
         b_base_q   <= b_base_d;
         rd_vld_q   <= rd_vld_d;
         rd_idx_q   <= rd_idx_d;
         for (int unsigned k = 0; k < NUM_READS; k++) ops_q[k] <= ops_d[k];
         mem_rd_q   <= mem_rd_d;
         mem_addr_q <= mem_addr_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         ce_q       <= ce_d;
         west_q     <= west_d;
         north_q    <= north_d;
      end
   end

   assign mem_rd      = mem_rd_q;
   assign mem_addr    = mem_addr_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign ce          = ce_q;
   assign west_input  = west_q;
   assign north_input = north_q;

endmodule

// File: tb/tb_skew_feeder.sv
// tb_skew_feeder: directed and randomized bench for skew_feeder with a
// behavioural byte memory and a cycle-indexed reference model of the
// expected output trace.
module tb_skew_feeder;

   localparam int N    = 16;
   localparam int G    = 2;
   localparam int AW   = 5;
   localparam int DR   = 3;
   localparam int MEMN = 1 << AW;
   localparam int STR0 = 10;
   localparam int DONE_CYC = STR0 + (2*G - 1) + DR;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            start;
   logic [AW-1:0]   a_base, b_base;
   logic            mem_rd;
   logic [AW-1:0]   mem_addr;
   logic [7:0]      mem_rdata;
   logic            busy, done, ce;
   logic [N*G-1:0]  west_input, north_input;

   int tests_run    = 0;
   int tests_failed = 0;

   int mem_bytes [MEMN];
   logic          pend_v = 1'b0;
   logic [AW-1:0] pend_a = '0;

   logic [N*G-1:0] ob_west  [DONE_CYC+1];
   logic [N*G-1:0] ob_north [DONE_CYC+1];
   logic [AW-1:0]  ob_addr  [DONE_CYC+1];

   skew_feeder dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a_base(a_base), .b_base(b_base),
      .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .busy(busy), .done(done), .ce(ce),
      .west_input(west_input), .north_input(north_input)
   );

   always #5 clk = ~clk;

   // Memory: data for a read seen in one cycle is presented during the next.
   always @(negedge clk) begin
      mem_rdata = pend_v ? 8'(mem_bytes[pend_a]) : 8'($urandom);
      pend_v    = mem_rd;
      pend_a    = mem_addr;
   end

   task automatic chk(input string tag, input int cyc, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
      end
   endtask

   function automatic int ref_ext(input int b);
`ifdef SKEW_FEEDER_SIGNED_EN
      return (b >= 128) ? (b + 65536 - 256) : b;
`else
      return b;
`endif
   endfunction

   task automatic chk_idle_zero(input string tag, input int cyc);
      chk({tag, "_busy"},  cyc, 64'(busy), 64'd0);
      chk({tag, "_done"},  cyc, 64'(done), 64'd0);
      chk({tag, "_ce"},    cyc, 64'(ce), 64'd0);
      chk({tag, "_rd"},    cyc, 64'(mem_rd), 64'd0);
      chk({tag, "_west"},  cyc, 64'(west_input), 64'd0);
      chk({tag, "_north"}, cyc, 64'(north_input), 64'd0);
   endtask

   // One operation: start at cycle 0, optional extra start pulses given by
   // smask bit c, optional reset at abort_cyc (-1 for none).
   task automatic run_op(input int a, input int b, input logic [31:0] smask, input int abort_cyc);
      int am [G][G];
      int bm [G][G];
      int e_west, e_north, t, k, e_addr;
      for (int i = 0; i < G; i++)
         for (int j = 0; j < G; j++) begin
            am[i][j] = ref_ext(mem_bytes[(a + G*i + j) % MEMN]);
            bm[i][j] = ref_ext(mem_bytes[(b + G*i + j) % MEMN]);
         end
      for (int c = 0; c <= DONE_CYC; c++) begin
         @(negedge clk);
         if (c == abort_cyc) begin
            rst_n = 1'b0;
            start = 1'b0;
            #1;
            chk_idle_zero("rst_now", c);
            for (int r = 0; r < 2; r++) begin
               @(negedge clk);
               chk_idle_zero("rst_hold", c + 1 + r);
            end
            rst_n = 1'b1;
            for (int r = 0; r < 3; r++) begin
               @(negedge clk);
               chk_idle_zero("post_rst", c + 3 + r);
            end
            return;
         end
         start = (c == 0) || smask[c];
         if (c == 0) begin
            a_base = AW'(a);
            b_base = AW'(b);
         end else begin
            a_base = AW'($urandom);
            b_base = AW'($urandom);
         end
         ob_west[c]  = west_input;
         ob_north[c] = north_input;
         ob_addr[c]  = mem_addr;
         // expected trace from cycle position
         e_west = 0;
         e_north = 0;
         if (c >= STR0 && c < STR0 + 2*G - 1) begin
            t = c - STR0;
            for (int i = 0; i < G; i++) begin
               k = t - i;
               if (k >= 0 && k < G) begin
                  e_west  += am[i][k] << (N*i);
                  e_north += bm[k][i] << (N*i);
               end
            end
         end
         chk("rd",    c, 64'(mem_rd), 64'(c >= 1 && c <= 2*G*G));
         if (c >= 1 && c <= 2*G*G) begin
            e_addr = (c <= G*G) ? (a + c - 1) % MEMN : (b + c - 1 - G*G) % MEMN;
            chk("addr", c, 64'(mem_addr), 64'(e_addr));
         end
         chk("busy",  c, 64'(busy), 64'(c >= 1 && c <= DONE_CYC));
         chk("done",  c, 64'(done), 64'(c == DONE_CYC));
         chk("ce",    c, 64'(ce),   64'(c >= STR0 && c < DONE_CYC));
         chk("west",  c, 64'(west_input),  64'(32'(e_west)));
         chk("north", c, 64'(north_input), 64'(32'(e_north)));
      end
   endtask

   initial begin
      rst_n  = 1'b0;
      start  = 1'b0;
      a_base = '0;
      b_base = '0;
      for (int i = 0; i < MEMN; i++) mem_bytes[i] = 0;
      repeat (2) @(negedge clk);
      chk_idle_zero("reset", 0);
      chk("reset_addr", 0, 64'(mem_addr), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk_idle_zero("after_rst", 0);

      // Reference example: A = 1..4, B = 5..8
      for (int i = 0; i < 8; i++) mem_bytes[i] = i + 1;
      run_op(0, 4, 32'h0, -1);
      chk("ex_w10", 10, 64'(ob_west[10]),  64'h0000_0001);
      chk("ex_w11", 11, 64'(ob_west[11]),  64'h0003_0002);
      chk("ex_w12", 12, 64'(ob_west[12]),  64'h0004_0000);
      chk("ex_n10", 10, 64'(ob_north[10]), 64'h0000_0005);
      chk("ex_n11", 11, 64'(ob_north[11]), 64'h0006_0007);
      chk("ex_n12", 12, 64'(ob_north[12]), 64'h0008_0000);

      // Address wrap, back-to-back start in the first idle cycle after done
      mem_bytes[30] = 8'h11; mem_bytes[31] = 8'h22;
      run_op(30, 2, 32'h0, -1);
      chk("wrap_a1", 1, 64'(ob_addr[1]), 64'd30);
      chk("wrap_a2", 2, 64'(ob_addr[2]), 64'd31);
      chk("wrap_a3", 3, 64'(ob_addr[3]), 64'd0);
      chk("wrap_a4", 4, 64'(ob_addr[4]), 64'd1);

      // Byte extension of 0xFF
      mem_bytes[8] = 8'hFF;
      run_op(8, 12, 32'h0, -1);
`ifdef SKEW_FEEDER_SIGNED_EN
      chk("ext_ff", 10, 64'(ob_west[10][N-1:0]), 64'hFFFF);
`else
      chk("ext_ff", 10, 64'(ob_west[10][N-1:0]), 64'h00FF);
`endif

      // Ignored start pulses in FETCH and DONE
      run_op(0, 4, (32'h1 << 5) | (32'h1 << DONE_CYC), -1);

      // Resets mid-FETCH, mid-STREAM, mid-DRAIN, each followed by a clean op
      run_op(0, 4, 32'h0, 11);
      run_op(0, 4, 32'h0, -1);
      run_op(3, 20, 32'h0, 4);
      run_op(3, 20, 32'h0, -1);
      run_op(7, 9, 32'h0, 14);

      // Randomized contents, bases and stray start pulses
      for (int n = 0; n < 12; n++) begin
         for (int i = 0; i < MEMN; i++) mem_bytes[i] = int'($urandom_range(0, 255));
         run_op(int'($urandom_range(0, MEMN-1)), int'($urandom_range(0, MEMN-1)),
                $urandom & ~32'h1, -1);
      end

      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      chk_idle_zero("final", 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
